// File: rtl/sm_hex_display_pkg.sv
// -----------------------------------------------------------------------------
// sm_hex_display_pkg
// Purpose : Shared definitions for the hex 7-segment display scanner.
//           Holds the scan FSM state encoding and the sixteen active-high
//           segment patterns (bit order {g,f,e,d,c,b,a}).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package sm_hex_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
   localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
   localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
   localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
   localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
   localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
   localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
   localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
   localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
   localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
   localparam logic [6:0] SEG_HEX_A = 7'b1110111;
   localparam logic [6:0] SEG_HEX_B = 7'b1111100;
   localparam logic [6:0] SEG_HEX_C = 7'b0111001;
   localparam logic [6:0] SEG_HEX_D = 7'b1011110;
   localparam logic [6:0] SEG_HEX_E = 7'b1111001;
   localparam logic [6:0] SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/sm_hex_display_hex_to_seg.sv
// -----------------------------------------------------------------------------
// sm_hex_to_seg
// Purpose : Combinational hex-digit to 7-segment decoder, active-high output.
// Ports   : nibble_i [3:0] - hex digit to decode
//           seg_o    [6:0] - segment pattern {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module sm_hex_to_seg
   import sm_hex_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_HEX_0;
      case (nibble_i)
         4'h0: seg_o = SEG_HEX_0;
         4'h1: seg_o = SEG_HEX_1;
         4'h2: seg_o = SEG_HEX_2;
         4'h3: seg_o = SEG_HEX_3;
         4'h4: seg_o = SEG_HEX_4;
         4'h5: seg_o = SEG_HEX_5;
         4'h6: seg_o = SEG_HEX_6;
         4'h7: seg_o = SEG_HEX_7;
         4'h8: seg_o = SEG_HEX_8;
         4'h9: seg_o = SEG_HEX_9;
         4'hA: seg_o = SEG_HEX_A;
         4'hB: seg_o = SEG_HEX_B;
         4'hC: seg_o = SEG_HEX_C;
         4'hD: seg_o = SEG_HEX_D;
         4'hE: seg_o = SEG_HEX_E;
         default: seg_o = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/sm_hex_display.sv
// -----------------------------------------------------------------------------
// sm_hex_display
// Purpose : Multiplexed 7-segment scanner for a 32-bit debug word. Digits are
//           scanned round-robin; each slot starts with a blanking gap (all
//           anodes off) to avoid ghosting. The word is snapshotted once per
//           frame so a frame never mixes old and new digits.
// Ports   : clk        - board clock
//           rst        - asynchronous reset, active-high
//           value      - word to display; digit i shows value[4i+3:4i]
//           enable     - scan enable, low = display dark
//           blankZeros - suppress leading zero digits (digit 0 always shown)
//           dpMask     - bit i lights the decimal point of digit i
//           seg        - segments {g,f,e,d,c,b,a}
//           dp         - decimal point
//           anode      - digit select, one-hot when active
//           frameStart - one-cycle pulse at the first cycle of each frame
// All outputs are registered; ACTIVE_LOW selects output polarity.
// -----------------------------------------------------------------------------
module sm_hex_display
   import sm_hex_display_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SLOT_W       = 16,
   parameter int BLANK_CYCLES = 64,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       value,
   input  logic              enable,
   input  logic              blankZeros,
   input  logic [DIGITS-1:0] dpMask,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] anode,
   output logic              frameStart
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

   // Idle (dark) output levels; XOR with these converts active-high to the
   // configured polarity.
   localparam logic              POL         = (ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] ANODE_OFF   = {DIGITS{POL}};
   localparam logic [6:0]        SEG_OFF_LVL = {7{POL}};

   state_t              state_q, state_d;
   logic [SLOT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [31:0]         snap_q,  snap_d;
   logic                fs_q,    fs_d;
   logic [6:0]          seg_q,   seg_d;
   logic                dp_q,    dp_d;
   logic [DIGITS-1:0]   anode_q, anode_d;

   logic [3:0]          nib;
   logic [6:0]          hex_seg;
   logic                dp_sel;
   logic [DIGITS-1:0]   onehot;
   logic [DIGITS-1:0]   zero_above;
   logic                zero_sel;
   logic                suppress;
   logic                show;

   // ---------------------------------------------------------------------------
   // Scan FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      fs_d    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = '0;
               snap_d  = value;
               fs_d    = 1'b1;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + SLOT_W'(1);
               if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
               // Counter wraps naturally to 0 at the slot boundary.
               cnt_d = cnt_q + SLOT_W'(1);
               if (&cnt_q) begin
                  state_d = ST_BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     snap_d = value;
                     fs_d   = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Digit select and leading-zero detection, from next-state values so the
   // registered outputs line up with the state they describe
   // ---------------------------------------------------------------------------
   always_comb begin
      nib    = snap_d[3:0];
      dp_sel = dpMask[0];
      onehot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            nib       = snap_d[4*i +: 4];
            dp_sel    = dpMask[i];
            onehot[i] = 1'b1;
         end
      end
   end

   // zero_above[i] is set when nibbles i..DIGITS-1 are all zero.
   always_comb begin
      zero_above = '0;
      zero_above[DIGITS-1] = (snap_d[4*(DIGITS-1) +: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] & (snap_d[4*i +: 4] == 4'h0);
      end
   end

   always_comb begin
      zero_sel = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) zero_sel = zero_above[i];
      end
   end

   sm_hex_to_seg u_hex_to_seg (
      .nibble_i (nib),
      .seg_o    (hex_seg)
   );

   // A suppressed digit keeps its slot timing but lights nothing.
   always_comb begin
      suppress = blankZeros && (idx_d != '0) && zero_sel;
      show     = (state_d == ST_SHOW) && !suppress;
      anode_d  = (show ? onehot : '0) ^ ANODE_OFF;
      seg_d    = (show ? hex_seg : 7'b0) ^ SEG_OFF_LVL;
      dp_d     = (show & dp_sel) ^ POL;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         fs_q    <= 1'b0;
         seg_q   <= SEG_OFF_LVL;
         dp_q    <= POL;
         anode_q <= ANODE_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         fs_q    <= fs_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         anode_q <= anode_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign anode      = anode_q;
   assign frameStart = fs_q;

endmodule

// File: tb/tb_sm_hex_display.sv
// -----------------------------------------------------------------------------
// tb_sm_hex_display
// Self-checking bench for sm_hex_display with DIGITS=4, SLOT_W=4,
// BLANK_CYCLES=2, ACTIVE_LOW=1. A frame-position model (cycle number within
// the frame, snapshotted word) predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sm_hex_display;

   localparam int DIGITS = 4;
   localparam int SLOT   = 16;
   localparam int BLANK  = 2;
   localparam int FRAME  = DIGITS * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] value = 32'h0;
   logic        enable = 1'b0;
   logic        blankZeros = 1'b0;
   logic [3:0]  dpMask = 4'h0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  anode;
   logic        frameStart;

   int checks = 0;
   int errors = 0;

   // Active-low segment patterns for 0..F.
   logic [6:0] seg_tbl [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Reference model state
   bit          m_run = 0;
   int          m_t = 0;
   logic [31:0] m_snap = 32'h0;
   logic        m_bz = 1'b0;
   logic [3:0]  m_dpm = 4'h0;

   always #5 clk = ~clk;

   sm_hex_display #(
      .DIGITS       (4),
      .SLOT_W       (4),
      .BLANK_CYCLES (2),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .enable     (enable),
      .blankZeros (blankZeros),
      .dpMask     (dpMask),
      .seg        (seg),
      .dp         (dp),
      .anode      (anode),
      .frameStart (frameStart)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at %0t: observed %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at the edge.
   task automatic model_edge();
      if (rst || !enable) begin
         m_run = 0;
      end else if (!m_run) begin
         m_run  = 1;
         m_t    = 0;
         m_snap = value;
      end else begin
         m_t = (m_t + 1) % FRAME;
         if (m_t == 0) m_snap = value;
      end
      m_bz  = blankZeros;
      m_dpm = dpMask;
   endtask

   task automatic check_all();
      logic [3:0]  ea;
      logic [6:0]  es;
      logic        ed;
      logic        ef;
      bit          cmp_sd;
      int          digit;
      int          pos;
      logic [15:0] upper;
      ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0; cmp_sd = 1;
      if (m_run && !rst) begin
         digit = m_t / SLOT;
         pos   = m_t % SLOT;
         ef    = (m_t == 0);
         if (pos >= BLANK) begin
            upper = m_snap[15:0] >> (4 * digit);
            if (m_bz && digit > 0 && upper == 16'h0) begin
               cmp_sd = 0;
            end else begin
               ea = ~(4'b0001 << digit);
               es = seg_tbl[upper[3:0]];
               ed = ~m_dpm[digit];
            end
         end
      end
      chk("anode", {4'h0, anode}, {4'h0, ea});
      if (cmp_sd) begin
         chk("seg", {1'b0, seg}, {1'b0, es});
         chk("dp", {7'h0, dp}, {7'h0, ed});
      end
      chk("frameStart", {7'h0, frameStart}, {7'h0, ef});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_anode", {4'h0, anode}, 8'h0F);
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_dp", {7'h0, dp}, 8'h01);
      chk("rst_fs", {7'h0, frameStart}, 8'h00);
      tick(); tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) tick();

      // 1: basic scan of 0x1234
      value = 32'h1234; blankZeros = 1'b0; dpMask = 4'h0; enable = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 1)  chk("s1_fs1", {7'h0, frameStart}, 8'h01);
         if (k == 2)  chk("s1_blank", {4'h0, anode}, 8'h0F);
         if (k == 3)  chk("s1_dig0", {1'b0, seg}, {1'b0, 7'b0011001});
         if (k == 17) chk("s1_gap", {4'h0, anode}, 8'h0F);
         if (k == 19) chk("s1_dig1", {1'b0, seg}, {1'b0, 7'b0110000});
         if (k == 65) chk("s1_fs65", {7'h0, frameStart}, 8'h01);
      end

      // 2: leading-zero suppression
      enable = 1'b0; tick();
      value = 32'h0005; blankZeros = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 130; k++) begin
         tick();
         if (k == 3)  chk("s2_five", {1'b0, seg}, {1'b0, 7'b0010010});
         if (k == 20) chk("s2_sup1", {4'h0, anode}, 8'h0F);
         if (k == 52) chk("s2_sup3", {4'h0, anode}, 8'h0F);
         if (k == 40) value = 32'h0;
         if (k == 67) chk("s2_zero", {1'b0, seg}, {1'b0, 7'b1000000});
      end

      // 3: snapshot holds for the whole frame
      enable = 1'b0; tick();
      value = 32'hAAAA; blankZeros = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 19) value = 32'hBBBB;
         if (k == 35) chk("s3_A", {1'b0, seg}, {1'b0, 7'b0001000});
         if (k == 60) chk("s3_A3", {1'b0, seg}, {1'b0, 7'b0001000});
         if (k == 67) chk("s3_b", {1'b0, seg}, {1'b0, 7'b0000011});
      end

      // 4: drop enable during SHOW, then restart
      value = 32'h1234;
      enable = 1'b0;
      tick();
      chk("s4_dark_an", {4'h0, anode}, 8'h0F);
      chk("s4_dark_seg", {1'b0, seg}, 8'h7F);
      chk("s4_dark_fs", {7'h0, frameStart}, 8'h00);
      enable = 1'b1;
      tick();
      chk("s4_restart_fs", {7'h0, frameStart}, 8'h01);
      tick(); tick();
      chk("s4_dig0", {4'h0, anode}, 8'h0E);

      // 5: asynchronous reset mid-SHOW
      for (int k = 0; k < 5; k++) tick();
      #2 rst = 1'b1;
      m_run = 0;
      #1;
      chk("s5_async_an", {4'h0, anode}, 8'h0F);
      chk("s5_async_seg", {1'b0, seg}, 8'h7F);
      check_all();
      tick(); tick();
      #3 rst = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 1)  chk("s5_fs1", {7'h0, frameStart}, 8'h01);
         if (k == 3)  chk("s5_dig0", {1'b0, seg}, {1'b0, 7'b0011001});
         if (k == 65) chk("s5_fs65", {7'h0, frameStart}, 8'h01);
      end

      // 6: decimal point on digit 2 only
      enable = 1'b0; tick();
      dpMask = 4'b0100; enable = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 35) begin
            chk("s6_an2", {4'h0, anode}, 8'h0B);
            chk("s6_seg2", {1'b0, seg}, {1'b0, 7'b0100100});
            chk("s6_dp2", {7'h0, dp}, 8'h00);
         end
         if (k == 20) chk("s6_dp1", {7'h0, dp}, 8'h01);
      end

      // Randomized operation against the model
      for (int k = 0; k < 1500; k++) begin
         if (!enable) begin
            if ($urandom_range(0, 1) == 0) enable = 1'b1;
         end else if ($urandom_range(0, 99) < 2) begin
            enable = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: value = $urandom;
               1: value = $urandom & 32'h0000_00FF;
               2: value = $urandom & 32'h0000_000F;
               default: value = 32'h0;
            endcase
         end
         if ($urandom_range(0, 31) == 0) blankZeros = ~blankZeros;
         if ($urandom_range(0, 7) == 0) dpMask = 4'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
